bcd_minsec_timer: RTL and testbench

//   MM:SS stopwatch/countdown core. Divides clk to a 1 Hz tick and counts packed-BCD minutes/seconds
//   up or down under start/stop, clear and load control. Feeds min_o/sec_o directly to the 4-digit

---
 rtl/bcd_minsec_timer_pkg.sv | 39 +++
 rtl/bcd_minsec_timer_digit.sv | 48 ++++
 rtl/bcd_minsec_timer.sv | 166 ++++++++++++++++
 tb/tb_bcd_minsec_timer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_minsec_timer_pkg.sv
// Shared definitions for the MM:SS timer: FSM states, BCD limits, time payload.
//   bcd_time_t     : packed {min tens, min units, sec tens, sec units}
//   bcd_time_valid : 1 when every digit is legal BCD and sec tens <= 5
package bcd_minsec_timer_pkg;

  localparam int unsigned DIGIT_W      = 4;
  localparam int unsigned DIGIT_MAX    = 9;
  localparam int unsigned SEC_TENS_MAX = 5;
  localparam logic [7:0]  MIN_MAX      = 8'h99;
  localparam logic [7:0]  SEC_MAX      = 8'h59;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [DIGIT_W-1:0] min_t;
    logic [DIGIT_W-1:0] min_u;
    logic [DIGIT_W-1:0] sec_t;
    logic [DIGIT_W-1:0] sec_u;
  } bcd_time_t;

  localparam bcd_time_t TIME_ZERO   = 16'h0000;
  localparam bcd_time_t TIME_MAX    = {MIN_MAX, SEC_MAX};
  // Values one step before the terminal count in each direction
  localparam bcd_time_t TIME_UP_PRE = 16'h9958;
  localparam bcd_time_t TIME_DN_PRE = 16'h0001;

  function automatic logic bcd_time_valid(input bcd_time_t t);
    return (t.min_t <= DIGIT_W'(DIGIT_MAX)) &&
           (t.min_u <= DIGIT_W'(DIGIT_MAX)) &&
           (t.sec_t <= DIGIT_W'(SEC_TENS_MAX)) &&
           (t.sec_u <= DIGIT_W'(DIGIT_MAX));
  endfunction

endpackage

// File: rtl/bcd_minsec_timer_digit.sv
// bcd_digit: one mod-MODULUS up/down BCD digit.
//   clk, rst      : clock, synchronous active-high reset
//   en_i          : step the digit this cycle
//   up_i          : 1 = increment, 0 = decrement
//   load_i        : load load_val_i (wins over en_i)
//   load_val_i    : value to load
//   value_o       : registered digit value
//   carry_c_o     : combinational carry (up) / borrow (down) into the next digit
module bcd_digit
  import bcd_minsec_timer_pkg::*;
#(
  parameter int unsigned MODULUS = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_i,
  input  logic               up_i,
  input  logic               load_i,
  input  logic [DIGIT_W-1:0] load_val_i,
  output logic [DIGIT_W-1:0] value_o,
  output logic               carry_c_o
);

  localparam logic [DIGIT_W-1:0] TOP = DIGIT_W'(MODULUS - 1);

  logic [DIGIT_W-1:0] value_q, value_d;

  // Next value: load, else wrap-around step
  always_comb begin
    value_d = value_q;
    if (load_i) begin
      value_d = load_val_i;
    end else if (en_i) begin
      if (up_i) value_d = (value_q == TOP) ? '0 : value_q + DIGIT_W'(1);
      else      value_d = (value_q == '0) ? TOP : value_q - DIGIT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) value_q <= '0;
    else     value_q <= value_d;
  end

  assign value_o   = value_q;
  // Digit wraps on this step, so the next digit must step too
  assign carry_c_o = en_i && !load_i && (up_i ? (value_q == TOP) : (value_q == '0));

endmodule

// File: rtl/bcd_minsec_timer.sv
// bcd_minsec_timer: MM:SS up/down stopwatch with 1 Hz prescaler.
//   clk, rst       : clock, synchronous active-high reset
//   start_stop_i   : pulse, toggles run/pause
//   clear_i        : pulse, zero time and stop
//   load_i         : pulse, preset time from load_min_i/load_sec_i and stop
//   load_min_i/sec : BCD preset (rejected if not valid BCD / sec > 59)
//   up_down_i      : 1 = count up, 0 = count down, sampled each tick
//   min_o, sec_o   : registered BCD time
//   running_o      : registered, 1 while running
//   done_o         : registered 1-cycle pulse on terminal count
module bcd_minsec_timer
  import bcd_minsec_timer_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_stop_i,
  input  logic       clear_i,
  input  logic       load_i,
  input  logic [7:0] load_min_i,
  input  logic [7:0] load_sec_i,
  input  logic       up_down_i,
  output logic [7:0] min_o,
  output logic [7:0] sec_o,
  output logic       running_o,
  output logic       done_o
);

  localparam int unsigned      PRESC_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

  state_e             state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               done_q, done_d;
  logic               running_q, running_d;

  bcd_time_t cur_t;
  bcd_time_t load_t;
  bcd_time_t dig_val;
  logic      dig_load;
  logic      step;
  logic      load_ok;
  logic      tick;
  logic      at_end;
  logic      pre_end;
  logic      su_carry, st_carry, mu_carry;
  logic      mt_carry_unused;

  assign load_t  = {load_min_i, load_sec_i};
  assign load_ok = bcd_time_valid(load_t);
  assign tick    = (state_q == ST_RUN) && (presc_q == PRESC_LAST);
  // Already at the terminal value for the current direction
  assign at_end  = up_down_i ? (cur_t == TIME_MAX) : (cur_t == TIME_ZERO);
  assign pre_end = up_down_i ? (cur_t == TIME_UP_PRE) : (cur_t == TIME_DN_PRE);

  // Next state, prescaler and time control; priority clear > load > start_stop > tick
  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    done_d   = 1'b0;
    step     = 1'b0;
    dig_load = 1'b0;
    dig_val  = load_t;

    if (clear_i) begin
      state_d  = ST_IDLE;
      presc_d  = '0;
      dig_load = 1'b1;
      dig_val  = TIME_ZERO;
    end else if (load_i) begin
      // An invalid preset consumes the cycle and changes nothing
      if (load_ok) begin
        state_d  = ST_IDLE;
        presc_d  = '0;
        dig_load = 1'b1;
      end
    end else if (start_stop_i) begin
      // Prescaler holds here so a pause keeps sub-second phase
      case (state_q)
        ST_RUN:            state_d = ST_PAUSE;
        ST_IDLE, ST_PAUSE: if (!at_end) state_d = ST_RUN;
        default:           state_d = state_q;
      endcase
    end else if (state_q == ST_RUN) begin
      if (tick) begin
        presc_d = '0;
        step    = !at_end;
        if (at_end || pre_end) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end else begin
        presc_d = presc_q + PRESC_W'(1);
      end
    end

    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      presc_q   <= '0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      done_q    <= done_d;
      running_q <= running_d;
    end
  end

  // Digit chain: sec units -> sec tens (mod 6) -> min units -> min tens
  bcd_digit #(.MODULUS(10)) u_sec_u (
    .clk        (clk),
    .rst        (rst),
    .en_i       (step),
    .up_i       (up_down_i),
    .load_i     (dig_load),
    .load_val_i (dig_val.sec_u),
    .value_o    (cur_t.sec_u),
    .carry_c_o  (su_carry)
  );

  bcd_digit #(.MODULUS(SEC_TENS_MAX + 1)) u_sec_t (
    .clk        (clk),
    .rst        (rst),
    .en_i       (su_carry),
    .up_i       (up_down_i),
    .load_i     (dig_load),
    .load_val_i (dig_val.sec_t),
    .value_o    (cur_t.sec_t),
    .carry_c_o  (st_carry)
  );

  bcd_digit #(.MODULUS(10)) u_min_u (
    .clk        (clk),
    .rst        (rst),
    .en_i       (st_carry),
    .up_i       (up_down_i),
    .load_i     (dig_load),
    .load_val_i (dig_val.min_u),
    .value_o    (cur_t.min_u),
    .carry_c_o  (mu_carry)
  );

  // Top digit never carries out: 99:59 and 00:00 are terminal and never stepped past
  bcd_digit #(.MODULUS(10)) u_min_t (
    .clk        (clk),
    .rst        (rst),
    .en_i       (mu_carry),
    .up_i       (up_down_i),
    .load_i     (dig_load),
    .load_val_i (dig_val.min_t),
    .value_o    (cur_t.min_t),
    .carry_c_o  (mt_carry_unused)
  );

  assign min_o     = {cur_t.min_t, cur_t.min_u};
  assign sec_o     = {cur_t.sec_t, cur_t.sec_u};
  assign running_o = running_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_bcd_minsec_timer.sv
// Testbench for bcd_minsec_timer (TICK_DIV = 4): directed scenarios with
// constant expectations, then random control traffic against a seconds-based model.
module tb_bcd_minsec_timer;

  localparam int unsigned TD    = 4;
  localparam int          T_MAX = 99 * 60 + 59;
  localparam int          M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_stop_i;
  logic       clear_i;
  logic       load_i;
  logic [7:0] load_min_i;
  logic [7:0] load_sec_i;
  logic       up_down_i;
  logic [7:0] min_o;
  logic [7:0] sec_o;
  logic       running_o;
  logic       done_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: time as total seconds, prescaler as a plain count
  int m_state;
  int m_t;
  int m_p;
  bit m_done;

  bcd_minsec_timer #(.TICK_DIV(TD)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_stop_i (start_stop_i),
    .clear_i      (clear_i),
    .load_i       (load_i),
    .load_min_i   (load_min_i),
    .load_sec_i   (load_sec_i),
    .up_down_i    (up_down_i),
    .min_o        (min_o),
    .sec_o        (sec_o),
    .running_o    (running_o),
    .done_o       (done_o)
  );

  always #5 clk = ~clk;

  function automatic int bcd2int(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [7:0] int2bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  task automatic model_update();
    bit valid;
    m_done = 1'b0;
    if (rst) begin
      m_state = M_IDLE; m_t = 0; m_p = 0;
    end else if (clear_i) begin
      m_state = M_IDLE; m_t = 0; m_p = 0;
    end else if (load_i) begin
      valid = (load_min_i[7:4] <= 4'd9) && (load_min_i[3:0] <= 4'd9) &&
              (load_sec_i[7:4] <= 4'd5) && (load_sec_i[3:0] <= 4'd9);
      if (valid) begin
        m_state = M_IDLE; m_p = 0;
        m_t = bcd2int(load_min_i) * 60 + bcd2int(load_sec_i);
      end
    end else if (start_stop_i) begin
      if (m_state == M_RUN) m_state = M_PAUSE;
      else if (m_state != M_DONE) begin
        if (!(up_down_i ? (m_t == T_MAX) : (m_t == 0))) m_state = M_RUN;
      end
    end else if (m_state == M_RUN) begin
      if (m_p == int'(TD) - 1) begin
        m_p = 0;
        if (up_down_i) begin
          if (m_t < T_MAX) m_t = m_t + 1;
          if (m_t == T_MAX) begin m_state = M_DONE; m_done = 1'b1; end
        end else begin
          if (m_t > 0) m_t = m_t - 1;
          if (m_t == 0) begin m_state = M_DONE; m_done = 1'b1; end
        end
      end else begin
        m_p = m_p + 1;
      end
    end
  endtask

  // One clock: model sees the driven inputs, DUT samples them, outputs read 1 time unit later
  task automatic step_clk();
    model_update();
    @(posedge clk);
    #1;
    rst = 1'b0; start_stop_i = 1'b0; clear_i = 1'b0; load_i = 1'b0;
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) step_clk();
  endtask

  task automatic pulse_ss();
    start_stop_i = 1'b1;
    step_clk();
  endtask

  task automatic do_load(input logic [7:0] m, input logic [7:0] s);
    load_min_i = m; load_sec_i = s; load_i = 1'b1;
    step_clk();
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    step_clk();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step_clk();
    n_checks++; if (min_o !== 8'h00) begin n_fail++; $display("FAIL reset_min: got %h want 00", min_o); end
    n_checks++; if (sec_o !== 8'h00) begin n_fail++; $display("FAIL reset_sec: got %h want 00", sec_o); end
    n_checks++; if (running_o !== 1'b0) begin n_fail++; $display("FAIL reset_running: got %b want 0", running_o); end
    n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done_o); end
  endtask

  task automatic test_count_up();
    up_down_i = 1'b1;
    pulse_ss();
    n_checks++; if (running_o !== 1'b1) begin n_fail++; $display("FAIL up_running: got %b want 1", running_o); end
    run_n(3);
    n_checks++; if (sec_o !== 8'h00) begin n_fail++; $display("FAIL up_before_tick: got %h want 00", sec_o); end
    run_n(1);
    n_checks++; if (sec_o !== 8'h01) begin n_fail++; $display("FAIL up_tick1: got %h want 01", sec_o); end
    run_n(4);
    n_checks++; if (sec_o !== 8'h02) begin n_fail++; $display("FAIL up_tick2: got %h want 02", sec_o); end
    n_checks++; if (running_o !== 1'b1) begin n_fail++; $display("FAIL up_still_running: got %b want 1", running_o); end
  endtask

  task automatic test_carry();
    up_down_i = 1'b1;
    do_load(8'h00, 8'h58);
    n_checks++; if ({min_o, sec_o} !== 16'h0058) begin n_fail++; $display("FAIL load_0058: got %h want 0058", {min_o, sec_o}); end
    n_checks++; if (running_o !== 1'b0) begin n_fail++; $display("FAIL load_stops: got %b want 0", running_o); end
    pulse_ss();
    run_n(4);
    n_checks++; if ({min_o, sec_o} !== 16'h0059) begin n_fail++; $display("FAIL carry_0059: got %h want 0059", {min_o, sec_o}); end
    run_n(4);
    n_checks++; if ({min_o, sec_o} !== 16'h0100) begin n_fail++; $display("FAIL carry_0100: got %h want 0100", {min_o, sec_o}); end
    do_load(8'h09, 8'h59);
    pulse_ss();
    run_n(4);
    n_checks++; if ({min_o, sec_o} !== 16'h1000) begin n_fail++; $display("FAIL carry_1000: got %h want 1000", {min_o, sec_o}); end
  endtask

  task automatic test_countdown_done();
    up_down_i = 1'b0;
    do_load(8'h00, 8'h02);
    pulse_ss();
    run_n(4);
    n_checks++; if ({min_o, sec_o} !== 16'h0001) begin n_fail++; $display("FAIL down_0001: got %h want 0001", {min_o, sec_o}); end
    n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL down_no_done: got %b want 0", done_o); end
    run_n(4);
    n_checks++; if ({min_o, sec_o} !== 16'h0000) begin n_fail++; $display("FAIL down_0000: got %h want 0000", {min_o, sec_o}); end
    n_checks++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL down_done_pulse: got %b want 1", done_o); end
    n_checks++; if (running_o !== 1'b0) begin n_fail++; $display("FAIL down_done_stopped: got %b want 0", running_o); end
    run_n(1);
    n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL down_done_one_cycle: got %b want 0", done_o); end
    pulse_ss();
    n_checks++; if (running_o !== 1'b0) begin n_fail++; $display("FAIL done_ignores_start: got %b want 0", running_o); end
    run_n(8);
    n_checks++; if ({min_o, sec_o} !== 16'h0000) begin n_fail++; $display("FAIL done_holds_time: got %h want 0000", {min_o, sec_o}); end
  endtask

  task automatic test_pause_phase();
    up_down_i = 1'b1;
    do_clear();
    pulse_ss();
    run_n(2);
    pulse_ss();
    n_checks++; if (running_o !== 1'b0) begin n_fail++; $display("FAIL pause_running: got %b want 0", running_o); end
    run_n(10);
    n_checks++; if (sec_o !== 8'h00) begin n_fail++; $display("FAIL pause_holds: got %h want 00", sec_o); end
    pulse_ss();
    run_n(1);
    n_checks++; if (sec_o !== 8'h00) begin n_fail++; $display("FAIL resume_early: got %h want 00", sec_o); end
    run_n(1);
    n_checks++; if (sec_o !== 8'h01) begin n_fail++; $display("FAIL resume_phase: got %h want 01", sec_o); end
    run_n(3);
    pulse_ss();
    n_checks++; if (sec_o !== 8'h01) begin n_fail++; $display("FAIL pause_on_tick: got %h want 01", sec_o); end
    run_n(5);
    pulse_ss();
    run_n(1);
    n_checks++; if (sec_o !== 8'h02) begin n_fail++; $display("FAIL resume_first_cycle_tick: got %h want 02", sec_o); end
  endtask

  task automatic test_load_reject_clear();
    do_load(8'h12, 8'h34);
    n_checks++; if ({min_o, sec_o} !== 16'h1234) begin n_fail++; $display("FAIL load_1234: got %h want 1234", {min_o, sec_o}); end
    do_load(8'h00, 8'h60);
    n_checks++; if ({min_o, sec_o} !== 16'h1234) begin n_fail++; $display("FAIL reject_sec60: got %h want 1234", {min_o, sec_o}); end
    do_load(8'h00, 8'h0A);
    n_checks++; if ({min_o, sec_o} !== 16'h1234) begin n_fail++; $display("FAIL reject_sec0A: got %h want 1234", {min_o, sec_o}); end
    do_load(8'hA0, 8'h00);
    n_checks++; if ({min_o, sec_o} !== 16'h1234) begin n_fail++; $display("FAIL reject_minA0: got %h want 1234", {min_o, sec_o}); end
    up_down_i = 1'b1;
    pulse_ss();
    run_n(3);
    clear_i = 1'b1;
    step_clk();
    n_checks++; if ({min_o, sec_o} !== 16'h0000) begin n_fail++; $display("FAIL clear_on_tick: got %h want 0000", {min_o, sec_o}); end
    n_checks++; if (running_o !== 1'b0) begin n_fail++; $display("FAIL clear_stops: got %b want 0", running_o); end
    run_n(5);
    n_checks++; if ({min_o, sec_o} !== 16'h0000) begin n_fail++; $display("FAIL clear_holds: got %h want 0000", {min_o, sec_o}); end
  endtask

  task automatic test_terminal_edges();
    up_down_i = 1'b0;
    pulse_ss();
    n_checks++; if (running_o !== 1'b0) begin n_fail++; $display("FAIL down_zero_start_ignored: got %b want 0", running_o); end
    up_down_i = 1'b1;
    do_load(8'h99, 8'h58);
    pulse_ss();
    run_n(4);
    n_checks++; if ({min_o, sec_o} !== 16'h9959) begin n_fail++; $display("FAIL up_9959: got %h want 9959", {min_o, sec_o}); end
    n_checks++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL up_done_pulse: got %b want 1", done_o); end
    run_n(9);
    n_checks++; if ({min_o, sec_o} !== 16'h9959) begin n_fail++; $display("FAIL up_no_wrap: got %h want 9959", {min_o, sec_o}); end
    do_load(8'h99, 8'h59);
    pulse_ss();
    n_checks++; if (running_o !== 1'b0) begin n_fail++; $display("FAIL up_max_start_ignored: got %b want 0", running_o); end
    up_down_i = 1'b0;
    pulse_ss();
    n_checks++; if (running_o !== 1'b1) begin n_fail++; $display("FAIL down_from_max_runs: got %b want 1", running_o); end
    run_n(2);
    up_down_i = 1'b1;
    run_n(2);
    n_checks++; if ({min_o, sec_o} !== 16'h9959) begin n_fail++; $display("FAIL flip_at_end_time: got %h want 9959", {min_o, sec_o}); end
    n_checks++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL flip_at_end_done: got %b want 1", done_o); end
  endtask

  task automatic test_random();
    int r;
    logic [15:0] exp_t;
    do_clear();
    for (int i = 0; i < 4000; i++) begin
      r = int'($urandom_range(99, 0));
      if (r < 2) begin
        clear_i = 1'b1;
      end else if (r < 6) begin
        load_i = 1'b1;
        case ($urandom_range(4, 0))
          0: begin load_min_i = 8'h99; load_sec_i = int2bcd(int'($urandom_range(59, 50))); end
          1: begin load_min_i = 8'h00; load_sec_i = int2bcd(int'($urandom_range(9, 0))); end
          2: begin load_min_i = int2bcd(int'($urandom_range(99, 0)));
                   load_sec_i = int2bcd(int'($urandom_range(59, 0))); end
          3: begin load_min_i = 8'($urandom); load_sec_i = 8'($urandom); end
          default: begin load_min_i = 8'h00; load_sec_i = 8'h01; end
        endcase
      end else if (r < 14) begin
        start_stop_i = 1'b1;
      end
      if ($urandom_range(99, 0) < 3) up_down_i = ~up_down_i;
      step_clk();
      exp_t = {int2bcd(m_t / 60), int2bcd(m_t % 60)};
      n_checks++; if ({min_o, sec_o} !== exp_t) begin n_fail++; $display("FAIL rnd_time cyc %0d: got %h want %h", i, {min_o, sec_o}, exp_t); end
      n_checks++; if (running_o !== (m_state == M_RUN)) begin n_fail++; $display("FAIL rnd_running cyc %0d: got %b want %b", i, running_o, (m_state == M_RUN)); end
      n_checks++; if (done_o !== m_done) begin n_fail++; $display("FAIL rnd_done cyc %0d: got %b want %b", i, done_o, m_done); end
    end
  endtask

  initial begin
    rst = 1'b1; start_stop_i = 1'b0; clear_i = 1'b0; load_i = 1'b0;
    load_min_i = 8'h00; load_sec_i = 8'h00; up_down_i = 1'b1;
    m_state = M_IDLE; m_t = 0; m_p = 0; m_done = 1'b0;
    test_reset();
    test_count_up();
    test_carry();
    test_countdown_done();
    test_pause_phase();
    test_load_reject_clear();
    test_terminal_edges();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
